dmx512_rx: RTL and testbench

//  DMX512 slot receiver: recovers break, MAB, start code and data slots from the synchronized RS-485 line.

---
 rtl/dmx_pkg.sv | 28 ++
 rtl/dmx_line_sync.sv | 45 ++++
 rtl/dmx512_rx.sv | 158 +++++++++++++++
 tb/tb_dmx512_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// DMX512 receiver shared constants and FSM state encoding.
// Imported by the line synchronizer and the slot receiver.
package dmx_pkg;

    localparam int         DMX_BAUD              = 250000;
    localparam logic [7:0] DMX_START_CODE_DIMMER = 8'h00;
    localparam int         DMX_MAX_SLOTS         = 512;
    localparam int         DMX_BREAK_US          = 88;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_BREAK     = 3'd1;
    localparam logic [2:0] ST_MAB       = 3'd2;
    localparam logic [2:0] ST_SLOT_WAIT = 3'd3;
    localparam logic [2:0] ST_START     = 3'd4;
    localparam logic [2:0] ST_DATA      = 3'd5;
    localparam logic [2:0] ST_STOP      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_BREAK     = ST_BREAK,
        S_MAB       = ST_MAB,
        S_SLOT_WAIT = ST_SLOT_WAIT,
        S_START     = ST_START,
        S_DATA      = ST_DATA,
        S_STOP      = ST_STOP
    } dmx_state_t;

endpackage

// File: rtl/dmx_line_sync.sv
// RS-485 line conditioning: 2-FF synchronizer, falling-edge pulse and
// saturating low-time counter whose saturation marks a break.
module dmx_line_sync #(
    parameter int BREAK_CLKS = 4224
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_line,
    output logic o_fall,
    output logic o_break
);

    localparam int LW = $clog2(BREAK_CLKS + 1);
    localparam logic [LW-1:0] LOW_SAT = LW'(BREAK_CLKS);

    logic          r_s1;
    logic          r_s2;
    logic          r_prev;
    logic [LW-1:0] r_low;

    // Sync chain resets to the idle (mark) level so no edge is seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
            r_low  <= '0;
        end else begin
            r_s1   <= i_line;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            if (r_s2) begin
                r_low <= '0;
            end else if (r_low != LOW_SAT) begin
                r_low <= r_low + 1'b1;
            end
        end
    end

    assign o_line  = r_s2;
    assign o_fall  = r_prev & ~r_s2;
    assign o_break = (r_low == LOW_SAT);

endmodule

// File: rtl/dmx512_rx.sv
// DMX512 slot receiver: break/MAB/start-code framing and per-slot
// (channel, data, write_strobe) events for the PWM table.
module dmx512_rx
    import dmx_pkg::*;
#(
    parameter int         CLK_HZ     = 48000000,
    parameter int         BAUD       = DMX_BAUD,
    parameter int         BREAK_CLKS = (CLK_HZ / 1000000) * DMX_BREAK_US,
    parameter logic [7:0] START_CODE = DMX_START_CODE_DIMMER,
    parameter int         MAX_SLOTS  = DMX_MAX_SLOTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dmx_in,
    output logic [7:0] data,
    output logic [8:0] channel,
    output logic       write_strobe,
    output logic       frame_start,
    output logic       frame_error,
    output logic       rx_active
);

    localparam int BIT_CLKS  = CLK_HZ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int TW        = $clog2(BIT_CLKS);

    localparam logic [TW-1:0] T_BIT    = TW'(BIT_CLKS - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(HALF_CLKS - 1);
    localparam logic [9:0]    SLOT_MAX = 10'(MAX_SLOTS);
    localparam logic [9:0]    SLOT_SAT = 10'(MAX_SLOTS + 1);

    logic w_line;
    logic w_fall;
    logic w_break;

    dmx_line_sync #(
        .BREAK_CLKS(BREAK_CLKS)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_line (dmx_in),
        .o_line (w_line),
        .o_fall (w_fall),
        .o_break(w_break)
    );

    dmx_state_t    r_state;
    logic [TW-1:0] r_tmr;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;
    logic [9:0]    r_slot;
    logic          r_stop_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tmr        <= '0;
            r_bitn       <= '0;
            r_shift      <= '0;
            r_slot       <= '0;
            r_stop_bad   <= 1'b0;
            data         <= '0;
            channel      <= '0;
            write_strobe <= 1'b0;
            frame_start  <= 1'b0;
            frame_error  <= 1'b0;
            rx_active    <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            frame_start  <= 1'b0;
            frame_error  <= 1'b0;
            if (w_break) begin
                r_state    <= S_BREAK;
                r_tmr      <= '0;
                r_slot     <= '0;
                r_stop_bad <= 1'b0;
                rx_active  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_tmr <= '0;
                    end
                    S_BREAK: begin
                        if (w_line) begin
                            r_state <= S_MAB;
                        end
                    end
                    S_MAB, S_SLOT_WAIT: begin
                        if (w_fall) begin
                            r_state <= S_START;
                            r_tmr   <= '0;
                        end
                    end
                    S_START: begin
                        if (r_tmr == T_HALF) begin
                            r_tmr   <= '0;
                            r_bitn  <= '0;
                            r_state <= w_line ? S_SLOT_WAIT : S_DATA;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_tmr == T_BIT) begin
                            r_tmr   <= '0;
                            r_shift <= {w_line, r_shift[7:1]};
                            r_bitn  <= r_bitn + 1'b1;
                            if (r_bitn == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end
                    S_STOP: begin
                        // A low stop bit is only an error once the line
                        // recovers; if it stays low it becomes a break.
                        if (r_stop_bad) begin
                            if (w_line) begin
                                frame_error <= 1'b1;
                                rx_active   <= 1'b0;
                                r_stop_bad  <= 1'b0;
                                r_state     <= S_IDLE;
                            end
                        end else if (r_tmr == T_BIT) begin
                            r_tmr <= '0;
                            if (!w_line) begin
                                r_stop_bad <= 1'b1;
                            end else begin
                                r_state <= S_SLOT_WAIT;
                                if (r_slot == 10'd0) begin
                                    if (r_shift == START_CODE) begin
                                        frame_start <= 1'b1;
                                        rx_active   <= 1'b1;
                                    end
                                end else if (rx_active &&
                                             r_slot <= SLOT_MAX) begin
                                    write_strobe <= 1'b1;
                                    data         <= r_shift;
                                    channel      <= 9'(r_slot - 10'd1);
                                end
                                if (r_slot != SLOT_SAT) begin
                                    r_slot <= r_slot + 1'b1;
                                end
                            end
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmx512_rx.sv
// Scoreboard bench for dmx512_rx: frame-level model predicts events,
// a forked monitor pops and compares whenever the DUT pulses.
`timescale 1ns/1ps
module tb_dmx512_rx;

    localparam int         BIT  = 8;
    localparam int         BRK  = 176;
    localparam int         MAXS = 512;
    localparam logic [7:0] SC   = 8'h00;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int kind;
        int ch;
        int dat;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dmx_in = 1'b1;
    logic [7:0] data;
    logic [8:0] channel;
    logic       write_strobe;
    logic       frame_start;
    logic       frame_error;
    logic       rx_active;

    dmx512_rx #(
        .CLK_HZ    (2000000),
        .BAUD      (250000),
        .BREAK_CLKS(BRK),
        .START_CODE(SC),
        .MAX_SLOTS (MAXS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dmx_in      (dmx_in),
        .data        (data),
        .channel     (channel),
        .write_strobe(write_strobe),
        .frame_start (frame_start),
        .frame_error (frame_error),
        .rx_active   (rx_active)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  last_fall = 0;
    int  ws_count = 0;
    int  last_ch = -1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act,
                             input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // kind: 0 frame_start, 1 write_strobe, 2 frame_error
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                if (frame_start && write_strobe)
                    chk("fs_ws_overlap", 1, 0);
                if (frame_start || write_strobe || frame_error) begin
                    ev_t e;
                    int  k;
                    k = frame_error ? 2 : (frame_start ? 0 : 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", k, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", k, e.kind);
                        if (k == 1) begin
                            chk("channel", int'(channel), e.ch);
                            chk("data", int'(data), e.dat);
                            ws_count++;
                            last_ch = int'(channel);
                        end
                        if (k != 2)
                            chk_range("latency", cyc - last_fall,
                                      9 * BIT, 11 * BIT);
                    end
                end
            end
        end
    endtask

    task automatic push_ev(input int k, input int c, input int d);
        ev_t e;
        e.kind = k;
        e.ch   = c;
        e.dat  = d;
        exp_q.push_back(e);
    endtask

    // cut = slots received with a good stop bit; err = slot 'cut' bad stop
    task automatic model_frame(input bq_t b, input int cut, input bit err);
        bit act;
        act = (cut > 0) && (b[0] == SC);
        if (act) push_ev(0, 0, 0);
        for (int i = 1; i < cut; i++)
            if (act && i <= MAXS) push_ev(1, i - 1, int'(b[i]));
        if (err) push_ev(2, 0, 0);
    endtask

    task automatic rand_frame(output bq_t q, input logic [7:0] sc,
                              input int n);
        q = {};
        q.push_back(sc);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    task automatic drive(input logic v, input int n);
        dmx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_slot(input logic [7:0] b, input int stop_low);
        last_fall = cyc;
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        if (stop_low > 0) drive(1'b0, stop_low * BIT);
        drive(1'b1, 2 * BIT);
    endtask

    task automatic send_slots(input bq_t q, input int from, input int to);
        for (int i = from; i < to; i++) send_slot(q[i], 0);
    endtask

    task automatic send_break();
        drive(1'b0, 200);
        drive(1'b1, 24);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_data"}, int'(data), 0);
        chk({tag, "_channel"}, int'(channel), 0);
        chk({tag, "_ws"}, int'(write_strobe), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_fe"}, int'(frame_error), 0);
        chk({tag, "_rx_active"}, int'(rx_active), 0);
    endtask

    initial begin
        bq_t        q;
        bq_t        q2;
        logic [7:0] pb;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        q = {8'h00, 8'h11, 8'h22, 8'h33};
        model_frame(q, 4, 1'b0);
        send_break();
        send_slots(q, 0, 4);
        chk("t1_rx_active", int'(rx_active), 1);
        chk("t1_drain", exp_q.size(), 0);

        rand_frame(q, 8'hCC, 5);
        model_frame(q, 6, 1'b0);
        send_break();
        send_slots(q, 0, 6);
        chk("t2_rx_active", int'(rx_active), 0);

        rand_frame(q, SC, 6);
        model_frame(q, 3, 1'b1);
        send_break();
        send_slots(q, 0, 3);
        send_slot(q[3], 1);
        send_slots(q, 4, 7);
        chk("t3_rx_active", int'(rx_active), 0);
        chk("t3_drain", exp_q.size(), 0);

        drive(1'b0, 160);
        drive(1'b1, 24);
        rand_frame(q, SC, 4);
        send_slots(q, 0, 5);
        chk("t4_rx_active", int'(rx_active), 0);

        rand_frame(q, SC, 12);
        model_frame(q, 10, 1'b0);
        send_break();
        send_slots(q, 0, 10);
        pb = q[10];
        last_fall = cyc;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(pb[i], BIT);
        drive(pb[4], BIT / 2);
        drive(1'b0, 200);
        drive(1'b1, 24);
        q2 = {8'h00, 8'h5A};
        model_frame(q2, 2, 1'b0);
        send_slots(q2, 0, 2);
        chk("t5_last_ch", last_ch, 0);
        chk("t5_drain", exp_q.size(), 0);

        ws_count = 0;
        rand_frame(q, SC, 520);
        model_frame(q, 521, 1'b0);
        send_break();
        send_slots(q, 0, 521);
        chk("t6_strobes", ws_count, 512);
        chk("t6_last_ch", last_ch, 511);
        chk("t6_rx_active", int'(rx_active), 1);

        drive(1'b0, BIT);
        drive(1'b1, BIT);
        drive(1'b0, BIT / 2);
        rst = 1'b0;
        #1;
        chk_zero_outputs("midbyte_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 8 * BIT);
        ws_count = 0;
        send_slots(q, 1, 6);
        chk("post_reset_strobes", ws_count, 0);
        chk("post_reset_rx_active", int'(rx_active), 0);

        q2 = {SC, 8'($urandom)};
        model_frame(q2, 2, 1'b0);
        send_break();
        send_slots(q2, 0, 2);

        for (int i = 0; i < 500 && exp_q.size() != 0; i++)
            @(negedge clk);
        chk("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
